// File: rtl/mbssoc_irq_collector_if.sv
// Signal bundle between the interrupt collector and its neighbours:
// device lines, core syscalls, APIC vector/ack and the config port.
interface mbssoc_irq_collector_if #(
  parameter int INT_WIDTH     = 8,
  parameter int SYSCODE_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic [INT_WIDTH-1:0]     dev_irq;
  logic                     syscall_req0;
  logic                     syscall_req1;
  logic [SYSCODE_WIDTH-1:0] syscall_code0_in;
  logic [SYSCODE_WIDTH-1:0] syscall_code1_in;
  logic [INT_WIDTH-1:0]     int_ack;
  logic                     cfg_we;
  logic [1:0]               cfg_addr;
  logic [DATA_WIDTH-1:0]    cfg_wdata;
  logic [DATA_WIDTH-1:0]    cfg_rdata;
  logic [INT_WIDTH-1:0]     int_vec;
  logic [SYSCODE_WIDTH-1:0] syscall_code0;
  logic [SYSCODE_WIDTH-1:0] syscall_code1;
  logic                     syscall_busy0;
  logic                     syscall_busy1;

  modport master (
    output dev_irq, syscall_req0, syscall_req1, syscall_code0_in, syscall_code1_in,
    output int_ack, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, int_vec, syscall_code0, syscall_code1, syscall_busy0, syscall_busy1
  );

  modport slave (
    input  dev_irq, syscall_req0, syscall_req1, syscall_code0_in, syscall_code1_in,
    input  int_ack, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, int_vec, syscall_code0, syscall_code1, syscall_busy0, syscall_busy1
  );
endinterface

// File: rtl/mbssoc_irq_collector.sv
// Interrupt collection stage ahead of the APIC: synchronises device lines,
// latches edge/level requests, merges core syscalls and exposes config regs.
module mbssoc_irq_collector #(
  parameter int INT_WIDTH     = 8,
  parameter int SYSCODE_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int SYSCALL0_BIT  = 6,
  parameter int SYSCALL1_BIT  = 7
) (
  input logic clk,
  input logic rst,
  mbssoc_irq_collector_if.slave bus
);

  localparam logic [INT_WIDTH-1:0] SYS_BITS =
    (INT_WIDTH'(1) << SYSCALL0_BIT) | (INT_WIDTH'(1) << SYSCALL1_BIT);

  logic [INT_WIDTH-1:0]     s1_q, s2_q, prev_q;
  logic [INT_WIDTH-1:0]     pend_q, pend_d;
  logic [INT_WIDTH-1:0]     ovf_q, ovf_d;
  logic [INT_WIDTH-1:0]     mask_q, mask_d;
  logic [INT_WIDTH-1:0]     edge_q, edge_d;
  logic [SYSCODE_WIDTH-1:0] code0_q, code0_d, code1_q, code1_d;

  logic [INT_WIDTH-1:0] wr_bits, sys_req, sys_acc, rise, set_ev, clr;
  logic [INT_WIDTH-1:0] evt_bits, w1c_pend, w1c_ovf, ovf_set;
  logic                 unused_wdata_hi;

  assign unused_wdata_hi = ^bus.cfg_wdata[DATA_WIDTH-1:INT_WIDTH];

  always_comb begin
    wr_bits = bus.cfg_wdata[INT_WIDTH-1:0];

    sys_req = '0;
    sys_req[SYSCALL0_BIT] = bus.syscall_req0;
    sys_req[SYSCALL1_BIT] = bus.syscall_req1;
    // A request arriving together with its own ack is accepted (request wins).
    sys_acc = sys_req & (~pend_q | bus.int_ack);

    // Syscall bits always behave as event bits regardless of edge_mode.
    evt_bits = edge_q | SYS_BITS;
    rise     = s2_q & ~prev_q & edge_q & ~SYS_BITS;
    set_ev   = rise | sys_acc;

    w1c_pend = (bus.cfg_we && bus.cfg_addr == 2'd2) ? wr_bits : '0;
    w1c_ovf  = (bus.cfg_we && bus.cfg_addr == 2'd3) ? wr_bits : '0;
    clr      = bus.int_ack | w1c_pend;

    pend_d  = (evt_bits & (set_ev | (pend_q & ~clr))) | (~evt_bits & s2_q);
    ovf_set = (rise | sys_req) & pend_q & ~bus.int_ack;
    ovf_d   = ovf_set | (ovf_q & ~w1c_ovf);

    mask_d = mask_q;
    if (bus.cfg_we && bus.cfg_addr == 2'd0) mask_d = wr_bits & ~SYS_BITS;
    edge_d = edge_q;
    if (bus.cfg_we && bus.cfg_addr == 2'd1) edge_d = wr_bits;

    code0_d = sys_acc[SYSCALL0_BIT] ? bus.syscall_code0_in : code0_q;
    code1_d = sys_acc[SYSCALL1_BIT] ? bus.syscall_code1_in : code1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '1;
      code0_q <= '0;
      code1_q <= '0;
    end else begin
      s1_q    <= bus.dev_irq & ~SYS_BITS;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      code0_q <= code0_d;
      code1_q <= code1_d;
    end
  end

  always_comb begin
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = DATA_WIDTH'(mask_q);
      2'd1:    bus.cfg_rdata = DATA_WIDTH'(edge_q);
      2'd2:    bus.cfg_rdata = DATA_WIDTH'(pend_q);
      default: bus.cfg_rdata = DATA_WIDTH'(ovf_q);
    endcase
  end

  assign bus.int_vec       = pend_q & (mask_q | SYS_BITS);
  assign bus.syscall_code0 = code0_q;
  assign bus.syscall_code1 = code1_q;
  assign bus.syscall_busy0 = pend_q[SYSCALL0_BIT];
  assign bus.syscall_busy1 = pend_q[SYSCALL1_BIT];

endmodule

// File: tb/tb_mbssoc_irq_collector.sv
// Bench for mbssoc_irq_collector: directed vector table, async reset
// sequences, then randomized traffic against a cycle-level reference model.
module tb_mbssoc_irq_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mbssoc_irq_collector_if #(.INT_WIDTH(8), .SYSCODE_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mbssoc_irq_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [7:0]  dev;
    logic        r0;
    logic [7:0]  c0;
    logic        r1;
    logic [7:0]  c1;
    logic [7:0]  ack;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [7:0]  e_vec;
    logic [31:0] e_rd;
    logic [7:0]  e_c0;
    logic [7:0]  e_c1;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: dev_hist[k] is dev_irq sampled k+1 edges ago.
  logic [7:0] m_mask, m_edge, m_pend, m_ovf, m_c0, m_c1;
  logic [7:0] dev_hist[3];

  function automatic void model_reset();
    m_mask = 8'h00; m_edge = 8'hFF; m_pend = 8'h00; m_ovf = 8'h00;
    m_c0 = 8'h00; m_c1 = 8'h00;
    for (int k = 0; k < 3; k++) dev_hist[k] = 8'h00;
  endfunction

  function automatic void model_step();
    logic [7:0] np, no;
    logic [7:0] wbits;
    np = m_pend;
    no = m_ovf;
    wbits = bus.cfg_wdata[7:0];
    for (int i = 0; i < 8; i++) begin
      logic ack, w1p, w1o, req, rise, set, over;
      ack = bus.int_ack[i];
      w1p = bus.cfg_we && bus.cfg_addr == 2'd2 && wbits[i];
      w1o = bus.cfg_we && bus.cfg_addr == 2'd3 && wbits[i];
      over = 1'b0;
      if (i == 6 || i == 7) begin
        req  = (i == 6) ? bus.syscall_req0 : bus.syscall_req1;
        set  = req && (!m_pend[i] || ack);
        over = req && m_pend[i] && !ack;
        if (set)            np[i] = 1'b1;
        else if (ack || w1p) np[i] = 1'b0;
        if (set && i == 6) m_c0 = bus.syscall_code0_in;
        if (set && i == 7) m_c1 = bus.syscall_code1_in;
      end else if (m_edge[i]) begin
        rise = dev_hist[1][i] && !dev_hist[2][i];
        over = rise && m_pend[i] && !ack;
        if (rise)            np[i] = 1'b1;
        else if (ack || w1p) np[i] = 1'b0;
      end else begin
        np[i] = dev_hist[1][i];
      end
      if (over)     no[i] = 1'b1;
      else if (w1o) no[i] = 1'b0;
    end
    m_pend = np;
    m_ovf  = no;
    if (bus.cfg_we && bus.cfg_addr == 2'd0) m_mask = wbits & 8'h3F;
    if (bus.cfg_we && bus.cfg_addr == 2'd1) m_edge = wbits;
    dev_hist[2] = dev_hist[1];
    dev_hist[1] = dev_hist[0];
    dev_hist[0] = bus.dev_irq;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_mask};
      2'd1:    return {24'h0, m_edge};
      2'd2:    return {24'h0, m_pend};
      default: return {24'h0, m_ovf};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] dev, input logic r0, input logic [7:0] c0,
                       input logic r1, input logic [7:0] c1, input logic [7:0] ack,
                       input logic we, input logic [1:0] addr, input logic [31:0] wd);
    bus.dev_irq = dev;
    bus.syscall_req0 = r0; bus.syscall_code0_in = c0;
    bus.syscall_req1 = r1; bus.syscall_code1_in = c1;
    bus.int_ack = ack;
    bus.cfg_we = we; bus.cfg_addr = addr; bus.cfg_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic void row(input string n, input logic [7:0] dev, input logic r0,
      input logic [7:0] c0, input logic r1, input logic [7:0] c1, input logic [7:0] ack,
      input logic we, input logic [1:0] addr, input logic [31:0] wd, input logic [7:0] e_vec,
      input logic [31:0] e_rd, input logic [7:0] e_c0, input logic [7:0] e_c1,
      input logic [1:0] e_busy);
    vec_t v;
    v.name = n; v.dev = dev; v.r0 = r0; v.c0 = c0; v.r1 = r1; v.c1 = c1; v.ack = ack;
    v.we = we; v.addr = addr; v.wd = wd; v.e_vec = e_vec; v.e_rd = e_rd;
    v.e_c0 = e_c0; v.e_c1 = e_c1; v.e_busy = e_busy;
    tbl.push_back(v);
  endfunction

  task automatic check_outputs(input string n, input logic [7:0] e_vec, input logic [31:0] e_rd,
                               input logic [7:0] e_c0, input logic [7:0] e_c1,
                               input logic [1:0] e_busy);
    chk({n, ".int_vec"}, {24'h0, bus.int_vec}, {24'h0, e_vec});
    chk({n, ".cfg_rdata"}, bus.cfg_rdata, e_rd);
    chk({n, ".code0"}, {24'h0, bus.syscall_code0}, {24'h0, e_c0});
    chk({n, ".code1"}, {24'h0, bus.syscall_code1}, {24'h0, e_c1});
    chk({n, ".busy"}, {30'h0, bus.syscall_busy1, bus.syscall_busy0}, {30'h0, e_busy});
  endtask

  initial begin
    // name        dev  r0 c0  r1 c1  ack  we ad wd      vec  rd    c0   c1   busy
    row("mask_wr",   8'h00,0,8'h00,0,8'h00,8'h00,1,2'd0,32'hFF, 8'h00,32'h3F,8'h00,8'h00,2'b00);
    row("t1_e0",     8'h04,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t1_e1",     8'h04,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t1_e2",     8'h04,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h04,32'h04,8'h00,8'h00,2'b00);
    row("t1_e3",     8'h04,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h04,32'h04,8'h00,8'h00,2'b00);
    row("t1_ack",    8'h00,0,8'h00,0,8'h00,8'h04,0,2'd3,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t1_idle",   8'h00,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t1_flush",  8'h00,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t2_a",      8'h01,0,8'h00,0,8'h00,8'h00,0,2'd3,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t2_b",      8'h00,0,8'h00,0,8'h00,8'h00,0,2'd3,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t2_c",      8'h01,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h01,32'h01,8'h00,8'h00,2'b00);
    row("t2_d",      8'h00,0,8'h00,0,8'h00,8'h00,0,2'd3,32'h0,  8'h01,32'h00,8'h00,8'h00,2'b00);
    row("t2_ovf",    8'h00,0,8'h00,0,8'h00,8'h00,0,2'd3,32'h0,  8'h01,32'h01,8'h00,8'h00,2'b00);
    row("t2_w1c",    8'h00,0,8'h00,0,8'h00,8'h00,1,2'd3,32'h01, 8'h01,32'h00,8'h00,8'h00,2'b00);
    row("t2_ack",    8'h00,0,8'h00,0,8'h00,8'h01,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t3_mask0",  8'h00,0,8'h00,0,8'h00,8'h00,1,2'd0,32'h00, 8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t3_a",      8'h08,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t3_b",      8'h08,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t3_c",      8'h08,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h08,8'h00,8'h00,2'b00);
    row("t3_unmask", 8'h00,0,8'h00,0,8'h00,8'h00,1,2'd0,32'h08, 8'h08,32'h08,8'h00,8'h00,2'b00);
    row("t3_ack",    8'h00,0,8'h00,0,8'h00,8'h08,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t3_idle",   8'h00,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t4_mask",   8'h00,0,8'h00,0,8'h00,8'h00,1,2'd0,32'hFF, 8'h00,32'h3F,8'h00,8'h00,2'b00);
    row("t4_level",  8'h00,0,8'h00,0,8'h00,8'h00,1,2'd1,32'hFE, 8'h00,32'hFE,8'h00,8'h00,2'b00);
    row("t4_a",      8'h01,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t4_b",      8'h01,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t4_c",      8'h01,0,8'h00,0,8'h00,8'h01,0,2'd2,32'h0,  8'h01,32'h01,8'h00,8'h00,2'b00);
    row("t4_d",      8'h01,0,8'h00,0,8'h00,8'h01,0,2'd2,32'h0,  8'h01,32'h01,8'h00,8'h00,2'b00);
    row("t4_e",      8'h00,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h01,32'h01,8'h00,8'h00,2'b00);
    row("t4_f",      8'h00,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h01,32'h01,8'h00,8'h00,2'b00);
    row("t4_g",      8'h00,0,8'h00,0,8'h00,8'h00,0,2'd2,32'h0,  8'h00,32'h00,8'h00,8'h00,2'b00);
    row("t4_edge",   8'h00,0,8'h00,0,8'h00,8'h00,1,2'd1,32'hFF, 8'h00,32'hFF,8'h00,8'h00,2'b00);
    row("t5_req",    8'h00,1,8'h11,0,8'h00,8'h00,0,2'd2,32'h0,  8'h40,32'h40,8'h11,8'h00,2'b01);
    row("t5_busy",   8'h00,1,8'h22,0,8'h00,8'h00,0,2'd3,32'h0,  8'h40,32'h40,8'h11,8'h00,2'b01);
    row("t5_ack",    8'h00,0,8'h00,0,8'h00,8'h40,0,2'd3,32'h0,  8'h00,32'h40,8'h11,8'h00,2'b00);
    row("t5_w1c",    8'h00,0,8'h00,0,8'h00,8'h00,1,2'd3,32'h40, 8'h00,32'h00,8'h11,8'h00,2'b00);
    row("t6_req",    8'h00,0,8'h00,1,8'h44,8'h00,0,2'd2,32'h0,  8'h80,32'h80,8'h11,8'h44,2'b10);
    row("t6_race",   8'h00,0,8'h00,1,8'h33,8'h80,0,2'd3,32'h0,  8'h80,32'h00,8'h11,8'h33,2'b10);

    drive(8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 2'd1, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held", 8'h00, 32'hFF, 8'h00, 8'h00, 2'b00);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].dev, tbl[k].r0, tbl[k].c0, tbl[k].r1, tbl[k].c1, tbl[k].ack,
            tbl[k].we, tbl[k].addr, tbl[k].wd);
      tick();
      check_outputs(tbl[k].name, tbl[k].e_vec, tbl[k].e_rd, tbl[k].e_c0, tbl[k].e_c1,
                    tbl[k].e_busy);
    end

    // Async reset with bit 7 pending and code1 held: outputs must drop without a clock edge.
    drive(8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 2'd2, 32'h0);
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 8'h00, 32'h00, 8'h00, 8'h00, 2'b00);
    tick();
    model_reset();
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] flip;
      flip = 8'($urandom & $urandom & $urandom);
      drive(bus.dev_irq ^ flip,
            $urandom_range(0, 3) == 0, 8'($urandom),
            $urandom_range(0, 3) == 0, 8'($urandom),
            8'($urandom & $urandom),
            $urandom_range(0, 7) == 0, 2'($urandom), $urandom);
      tick();
      check_outputs($sformatf("rand%0d", n), m_pend & (m_mask | 8'hC0), model_rd(bus.cfg_addr),
                    m_c0, m_c1, {m_pend[7], m_pend[6]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbssoc_irq_collector.md
Name: mbssoc_irq_collector

Overview:
Interrupt collection stage directly upstream of the SoC interrupt controller (APIC). It synchronises raw device interrupt lines and latches edge-triggered requests into a pending register. It merges in the two cores' syscall requests and drives the registered int_vec and syscall codes that the APIC consumes. The APIC's int_ack bits retire pending requests. A small config port provides mask, edge/level mode, pending and overflow registers.

Parameters:
INT_WIDTH, 8, width of int_vec / int_ack / dev_irq (matches INT_SEL_WIDTH)
SYSCODE_WIDTH, 8, syscall code width
DATA_WIDTH, 32, config data width (INT_WIDTH <= DATA_WIDTH)
SYSCALL0_BIT, 6, int_vec bit position for core-0 syscall
SYSCALL1_BIT, 7, int_vec bit position for core-1 syscall

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
dev_irq  in  INT_WIDTH  raw device lines, asynchronous; bits at SYSCALL positions ignored
syscall_req0  in  1  one-cycle syscall request, core 0
syscall_req1  in  1  one-cycle syscall request, core 1
syscall_code0_in  in  SYSCODE_WIDTH  code for req0, valid with req0
syscall_code1_in  in  SYSCODE_WIDTH  code for req1, valid with req1
int_ack  in  INT_WIDTH  per-bit retire from APIC, sampled on rising edge
cfg_we  in  1  config write strobe
cfg_addr  in  2  0 mask, 1 edge_mode, 2 pending, 3 overflow
cfg_wdata  in  DATA_WIDTH  config write data (low INT_WIDTH bits used)
cfg_rdata  out  DATA_WIDTH  combinational read of cfg_addr, upper bits 0
int_vec  out  INT_WIDTH  pending & effective mask, to APIC
syscall_code0  out  SYSCODE_WIDTH  held code for core 0
syscall_code1  out  SYSCODE_WIDTH  held code for core 1
syscall_busy0  out  1  core-0 syscall pending; core must not issue another
syscall_busy1  out  1  core-1 syscall pending

Behaviour:
- Reset (async, any time, including mid-request):
  - sync flops, prev, pending, overflow, mask, codes: 0.
  - edge_mode: all 1.
  - Outputs 0.
- Device path, bit i not a syscall bit:
  - Two-flop synchroniser s1→s2, then prev <= s2.
  - Edge mode: rise = s2 & ~prev.
  - dev_irq rising before edge E0 gives int_vec[i]=1 after E2, provided mask[i]=1.
- Edge mode pending:
  - Set on rise.
  - Cleared at the rising edge where int_ack[i]=1.
  - Rise and ack in the same cycle: pending stays 1, no overflow.
  - Rise while already pending and no ack: overflow[i] <= 1 (sticky).
- Level mode (edge_mode[i]=0): pending[i] <= s2 every cycle; ack and W1C have no effect.
- Masking:
  - mask[i]=0 blocks int_vec[i] only.
  - Pending still latches and becomes visible when unmasked.
  - Syscall bits are never masked; mask bits at those positions read 0.
- Syscall path:
  - Applies to core n in {0,1} at bit SYSCALLn_BIT.
  - syscall_reqn with pending clear: pending bit <= 1 and syscall_coden <= code_in on the same edge; int_vec bit is visible the following cycle.
  - syscall_busyn = pending bit.
  - Request while busy: ignored, code unchanged, overflow bit set.
  - Ack clears the pending bit. The code holds its value until the next accepted request.
  - Ack and new request in the same cycle: the request wins and captures its code.
- Config writes (cfg_we, effective next edge):
  - addr 0 writes mask.
  - addr 1 writes edge_mode; a switch to level takes effect next cycle.
  - addr 2 is W1C on pending edge-mode bits; a set event in the same cycle wins.
  - addr 3 is W1C on overflow; a new overflow in the same cycle wins.
- Config reads:
  - addr 2 reads raw pending, unmasked.
  - addr 3 reads overflow.
- Bit precedence per cycle: reset > set event > ack / W1C > hold.

Test Plan:
- Reset then write mask=0xFF; pulse dev_irq[2] high for 4 cycles. Expect int_vec=0x04 from the third edge onward. Ack bit 2 for one cycle: int_vec=0x00 next cycle, overflow=0.
- Two rising edges on dev_irq[0] with no ack. Expect pending[0]=1, overflow read=0x01. W1C addr 3 with 0x01 → 0x00.
- mask=0x00, edge on dev_irq[3]. Expect int_vec=0 and cfg_rdata@2=0x08. Write mask=0x08 → int_vec=0x08 next cycle.
- edge_mode=0xFE, hold dev_irq[0] high. Expect int_vec[0]=1 throughout; ack has no effect. Drop line → int_vec[0]=0 after 2 cycles.
- syscall_req0 with code 0x11. Expect int_vec[6]=1, syscall_code0=0x11, busy0=1. Second req with 0x22 while busy: code stays 0x11, overflow[6]=1. Ack bit 6 → busy0=0.
- Same-cycle ack of bit 7 and syscall_req1 (code 0x33): expect bit 7 stays 1 and code=0x33. Assert rst mid-pending: all outputs 0 immediately.
